// File: rtl/reorder_buffer.sv
// Reorder buffer: records renamed instructions in program order, marks them done
// from writeback and retires at most one finished instruction per cycle from the head.
module reorder_buffer #(
    parameter int NUM_ENTRIES  = 16,
    parameter int NUM_REG      = 32,
    parameter int NUM_REG_LOG2 = 5,
    parameter int PREG_W       = 6,
    parameter int IDX_W        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [NUM_REG_LOG2-1:0] alloc_rd,
    input  logic [PREG_W-1:0]       alloc_prd_old,
    input  logic [PREG_W-1:0]       alloc_prd_new,
    output logic [IDX_W-1:0]        alloc_idx,
    input  logic                    wb_valid,
    input  logic [IDX_W-1:0]        wb_idx,
    input  logic                    flush,
    output logic                    commit_free,
    output logic [PREG_W-1:0]       prd_free,
    output logic                    commit_valid,
    output logic [NUM_REG_LOG2-1:0] commit_rd,
    output logic [PREG_W-1:0]       commit_prd_new,
    output logic [IDX_W:0]          count
);

    if ((NUM_ENTRIES < 4) || (NUM_ENTRIES != (1 << IDX_W)) || (NUM_REG != (1 << NUM_REG_LOG2))
        || (PREG_W != NUM_REG_LOG2 + 1)) begin : g_bad_cfg
        $error("reorder_buffer: inconsistent parameters");
    end

    logic [NUM_ENTRIES-1:0]  valid_q, valid_d;
    logic [NUM_ENTRIES-1:0]  done_q, done_d;
    logic [NUM_REG_LOG2-1:0] rd_mem      [NUM_ENTRIES];
    logic [PREG_W-1:0]       prd_old_mem [NUM_ENTRIES];
    logic [PREG_W-1:0]       prd_new_mem [NUM_ENTRIES];
    logic [IDX_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]          count_q, count_d;
    logic                    commit_valid_q, commit_valid_d;
    logic                    commit_free_q, commit_free_d;
    logic [PREG_W-1:0]       prd_free_q, prd_free_d;
    logic [PREG_W-1:0]       commit_prd_new_q, commit_prd_new_d;
    logic [NUM_REG_LOG2-1:0] commit_rd_q, commit_rd_d;
    logic                    alloc_fire, commit_fire;

    // No bypass from the same-cycle retirement: readiness is purely the registered count.
    assign alloc_ready = count_q < (IDX_W+1)'(NUM_ENTRIES);
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign commit_fire = valid_q[head_q] && done_q[head_q] && !flush;

    genvar gi;
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        logic alloc_hit, commit_hit, wb_hit;
        assign alloc_hit   = alloc_fire && (tail_q == IDX_W'(gi));
        assign commit_hit  = commit_fire && (head_q == IDX_W'(gi));
        assign wb_hit      = wb_valid && (wb_idx == IDX_W'(gi)) && valid_q[gi];
        // A fresh allocation wins over a writeback aimed at the same slot.
        assign valid_d[gi] = !flush && (alloc_hit || (valid_q[gi] && !commit_hit));
        assign done_d[gi]  = !flush && !alloc_hit && !commit_hit && (done_q[gi] || wb_hit);
    end

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        commit_valid_d   = commit_fire;
        commit_free_d    = 1'b0;
        prd_free_d       = prd_free_q;
        commit_rd_d      = commit_rd_q;
        commit_prd_new_d = commit_prd_new_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + 1'b1;
            end
            if (commit_fire) begin
                head_d           = head_q + 1'b1;
                commit_rd_d      = rd_mem[head_q];
                commit_prd_new_d = prd_new_mem[head_q];
                // x0 never owned a freeable register, so prd_free keeps its last value.
                if (rd_mem[head_q] != '0) begin
                    commit_free_d = 1'b1;
                    prd_free_d    = prd_old_mem[head_q];
                end
            end
            if (alloc_fire && !commit_fire) begin
                count_d = count_q + 1'b1;
            end else if (commit_fire && !alloc_fire) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            done_q           <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            commit_valid_q   <= 1'b0;
            commit_free_q    <= 1'b0;
            prd_free_q       <= '0;
            commit_rd_q      <= '0;
            commit_prd_new_q <= '0;
        end else begin
            valid_q          <= valid_d;
            done_q           <= done_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commit_valid_q   <= commit_valid_d;
            commit_free_q    <= commit_free_d;
            prd_free_q       <= prd_free_d;
            commit_rd_q      <= commit_rd_d;
            commit_prd_new_q <= commit_prd_new_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail_q]      <= alloc_rd;
            prd_old_mem[tail_q] <= alloc_prd_old;
            prd_new_mem[tail_q] <= alloc_prd_new;
        end
    end

    assign alloc_idx      = tail_q;
    assign count          = count_q;
    assign commit_valid   = commit_valid_q;
    assign commit_free    = commit_free_q;
    assign prd_free       = prd_free_q;
    assign commit_rd      = commit_rd_q;
    assign commit_prd_new = commit_prd_new_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model is compared
// against the DUT every cycle, with hand-computed literal checks at key points.
module tb_reorder_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [4:0] alloc_rd = '0;
    logic [5:0] alloc_prd_old = '0;
    logic [5:0] alloc_prd_new = '0;
    logic [3:0] alloc_idx;
    logic       wb_valid = 1'b0;
    logic [3:0] wb_idx = '0;
    logic       flush = 1'b0;
    logic       commit_free;
    logic [5:0] prd_free;
    logic       commit_valid;
    logic [4:0] commit_rd;
    logic [5:0] commit_prd_new;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit collect = 1'b0;
    int freed[$];

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_prd_old(alloc_prd_old), .alloc_prd_new(alloc_prd_new), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush),
        .commit_free(commit_free), .prd_free(prd_free), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_prd_new(commit_prd_new), .count(count)
    );

    always #5 clk = ~clk;

    // Model: in-flight instructions in program order, oldest at the front.
    typedef struct {
        int idx;
        int rd;
        int prd_old;
        int prd_new;
        bit done;
    } rob_ent_t;

    rob_ent_t mq[$];
    int m_tail = 0;
    int m_cv = 0;
    int m_cf = 0;
    int m_prd_free = 0;
    int m_rd = 0;
    int m_prd_new = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail = 0; m_cv = 0; m_cf = 0;
        m_prd_free = 0; m_rd = 0; m_prd_new = 0;
    endtask

    task automatic model_step();
        rob_ent_t e;
        bit do_commit;
        bit can_alloc;
        if (flush) begin
            mq.delete();
            m_tail = 0; m_cv = 0; m_cf = 0;
            return;
        end
        do_commit = (mq.size() > 0) && mq[0].done;
        can_alloc = mq.size() < 16;
        if (do_commit) begin
            e = mq.pop_front();
            m_cv = 1;
            m_cf = (e.rd != 0) ? 1 : 0;
            if (e.rd != 0) m_prd_free = e.prd_old;
            m_rd = e.rd;
            m_prd_new = e.prd_new;
        end else begin
            m_cv = 0; m_cf = 0;
        end
        if (wb_valid) begin
            foreach (mq[k]) if (mq[k].idx == int'(wb_idx)) mq[k].done = 1'b1;
        end
        if (alloc_valid && can_alloc) begin
            e.idx = m_tail; e.rd = int'(alloc_rd); e.prd_old = int'(alloc_prd_old);
            e.prd_new = int'(alloc_prd_new); e.done = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_alloc_ready", int'(alloc_ready), (mq.size() < 16) ? 1 : 0);
            check("cmp_alloc_idx", int'(alloc_idx), m_tail);
            check("cmp_count", int'(count), mq.size());
            check("cmp_commit_valid", int'(commit_valid), m_cv);
            check("cmp_commit_free", int'(commit_free), m_cf);
            check("cmp_prd_free", int'(prd_free), m_prd_free);
            check("cmp_commit_rd", int'(commit_rd), m_rd);
            check("cmp_commit_prd_new", int'(commit_prd_new), m_prd_new);
        end
        if (collect && commit_free) freed.push_back(int'(prd_free));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        tick();
        check("reset_alloc_ready", int'(alloc_ready), 1);
        check("reset_alloc_idx", int'(alloc_idx), 0);
        check("reset_count", int'(count), 0);
        check("reset_commit_valid", int'(commit_valid), 0);
        check("reset_prd_free", int'(prd_free), 0);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Three allocations
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
            alloc_prd_old = 6'(i + 1); alloc_prd_new = 6'(32 + i);
            check("alloc3_idx", int'(alloc_idx), i);
            tick();
        end
        alloc_valid = 1'b0;
        check("alloc3_count", int'(count), 3);
        check("alloc3_no_commit", int'(commit_valid), 0);

        // Out-of-order writebacks 2, 0, 1; in-order retirement
        wb_valid = 1'b1; wb_idx = 4'd2; tick();
        check("ooo_no_commit_a", int'(commit_valid), 0);
        wb_idx = 4'd0; tick();
        check("ooo_no_commit_b", int'(commit_valid), 0);
        wb_idx = 4'd1; tick();
        check("ooo_first_valid", int'(commit_valid), 1);
        check("ooo_first_free", int'(commit_free), 1);
        check("ooo_first_prd", int'(prd_free), 1);
        wb_valid = 1'b0; tick();
        check("ooo_second_prd", int'(prd_free), 2);
        tick();
        check("ooo_third_prd", int'(prd_free), 3);
        check("ooo_third_prd_new", int'(commit_prd_new), 34);
        tick();
        check("ooo_drained_valid", int'(commit_valid), 0);
        check("ooo_drained_count", int'(count), 0);

        // Fill all 16 entries, then attempt a 17th
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'd5;
            alloc_prd_old = 6'(i); alloc_prd_new = 6'(i + 10);
            tick();
        end
        check("full_ready", int'(alloc_ready), 0);
        check("full_count", int'(count), 16);
        alloc_rd = 5'd9; alloc_prd_old = 6'd63; alloc_prd_new = 6'd63;
        tick();
        check("full_17th_count", int'(count), 16);
        check("full_17th_idx", int'(alloc_idx), 3);
        alloc_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wb_valid = 1'b1; wb_idx = 4'((3 + i) % 16);
            tick();
        end
        wb_valid = 1'b0;
        tick(2);
        check("full_drained_count", int'(count), 0);
        check("full_last_prd", int'(prd_free), 15);

        // rd = 0 retires without freeing
        alloc_valid = 1'b1; alloc_rd = 5'd0; alloc_prd_old = 6'd0; alloc_prd_new = 6'd0;
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_idx = 4'd3;
        tick();
        wb_valid = 1'b0;
        tick();
        check("x0_commit_valid", int'(commit_valid), 1);
        check("x0_commit_free", int'(commit_free), 0);
        check("x0_prd_free_held", int'(prd_free), 15);
        check("x0_commit_rd", int'(commit_rd), 0);

        // Wrap-around streaming: alloc i, writeback i-1, commit i-2
        collect = 1'b1;
        for (int i = 0; i < 42; i++) begin
            alloc_valid = (i < 40);
            alloc_rd = 5'((i % 31) + 1); alloc_prd_old = 6'(i); alloc_prd_new = 6'(i + 20);
            wb_valid = (i >= 1) && (i <= 40);
            wb_idx = 4'((4 + i - 1) % 16);
            if (i == 20) check("wrap_steady_count", int'(count), 2);
            tick();
        end
        alloc_valid = 1'b0; wb_valid = 1'b0;
        collect = 1'b0;
        check("wrap_freed_len", freed.size(), 40);
        for (int k = 0; k < 40; k++) begin
            check("wrap_prd_free_seq", (k < freed.size()) ? freed[k] : -1, k);
        end
        check("wrap_tail", int'(alloc_idx), 12);

        // Flush with 5 entries, 2 done (not the head)
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
            alloc_prd_old = 6'(i + 1); alloc_prd_new = 6'(i + 40);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_idx = 4'd13; tick();
        wb_idx = 4'd14; tick();
        flush = 1'b1; alloc_valid = 1'b1; wb_idx = 4'd12;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
        check("flush_count", int'(count), 0);
        check("flush_alloc_idx", int'(alloc_idx), 0);
        check("flush_commit_valid", int'(commit_valid), 0);
        tick();
        check("flush_after_commit_valid", int'(commit_valid), 0);

        // Same setup, then an asynchronous reset mid-cycle while a commit pulse is out
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
            alloc_prd_old = 6'(20 + i); alloc_prd_new = 6'(40 + i);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_idx = 4'd1; tick();
        wb_idx = 4'd2; tick();
        wb_idx = 4'd0; tick();
        wb_valid = 1'b0; tick();
        check("prerst_commit_valid", int'(commit_valid), 1);
        check("prerst_prd_free", int'(prd_free), 20);
        #2 rst = 1'b0;
        #1;
        check("arst_commit_valid", int'(commit_valid), 0);
        check("arst_commit_free", int'(commit_free), 0);
        check("arst_prd_free", int'(prd_free), 0);
        check("arst_commit_rd", int'(commit_rd), 0);
        check("arst_commit_prd_new", int'(commit_prd_new), 0);
        check("arst_count", int'(count), 0);
        check("arst_alloc_idx", int'(alloc_idx), 0);
        tick();
        rst = 1'b1;
        tick(2);
        check("post_rst_commit_valid", int'(commit_valid), 0);
        check("post_rst_ready", int'(alloc_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
